// File: rtl/cv32e40x_uop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40x_uop_sequencer
// Description : ID-stage Zcmp expander. Turns cm.push/pop/popret/popretz/
//               mvsa01/mva01s into a sequence of RV32I micro-ops and passes
//               every other instruction straight through in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40x_uop_sequencer #(
  parameter int unsigned ZC_EXT    = 1,
  parameter int unsigned RLIST_MIN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        instr_compressed_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        kill_i,
  output logic [31:0] uop_o,
  output logic        uop_valid_o,
  input  logic        uop_ready_i,
  output logic        uop_first_o,
  output logic        uop_last_o,
  output logic        seq_active_o
);

  localparam logic [0:0] S_IDLE      = 1'b0;
  localparam logic [0:0] S_SEQ       = 1'b1;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam logic [4:0] REG_RA      = 5'd1;
  localparam logic [4:0] REG_SP      = 5'd2;
  localparam logic [4:0] REG_A0      = 5'd10;
  localparam logic [4:0] REG_A1      = 5'd11;

  localparam logic [4:0] RLIST_MIN_L = 5'(RLIST_MIN);
  localparam logic       ZC_EN       = (ZC_EXT != 0);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [15:0] c_instr;
  logic [3:0]  rlist;
  logic [1:0]  spimm;
  logic [2:0]  r1s, r2s;
  logic        is_push, is_pop, is_popret, is_popretz, is_pp;
  logic        is_mv, is_mvsa, is_mva;
  logic        rlist_ok;
  logic        expand;

  logic [3:0]  n_regs;
  logic [7:0]  bytes_regs;
  logic [7:0]  adj;
  logic [3:0]  len_m1;
  logic        is_last;

  logic [3:0]  tail_k;
  logic [3:0]  reg_idx;
  logic [11:0] off4;
  logic [11:0] adj12;
  logic [31:0] gen_uop;

  // ---------------------------------------------------------------------------
  // Encoding helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] enc_itype(input logic [4:0]  rd,
                                            input logic [4:0]  rs1,
                                            input logic [2:0]  f3,
                                            input logic [6:0]  opc,
                                            input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_store(input logic [4:0]  rs2,
                                            input logic [4:0]  rs1,
                                            input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
  endfunction

  // Register list order: ra, s0, s1, s2..s11
  function automatic logic [4:0] rlist_reg(input logic [3:0] k);
    logic [4:0] r;
    if (k == 4'd0)      r = 5'd1;
    else if (k == 4'd1) r = 5'd8;
    else if (k == 4'd2) r = 5'd9;
    else                r = {1'b0, k} + 5'd15;
    return r;
  endfunction

  // s' encoding: 0,1 -> x8,x9 ; 2..7 -> x18..x23
  function automatic logic [4:0] sreg(input logic [2:0] s);
    return (s < 3'd2) ? {2'b01, s} : {2'b10, s};
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  assign c_instr    = instr_i[15:0];
  assign rlist      = c_instr[7:4];
  assign spimm      = c_instr[3:2];
  assign r1s        = c_instr[9:7];
  assign r2s        = c_instr[4:2];

  assign is_push    = (c_instr[15:8] == 8'hB8) && (c_instr[1:0] == 2'b10);
  assign is_pop     = (c_instr[15:8] == 8'hBA) && (c_instr[1:0] == 2'b10);
  assign is_popretz = (c_instr[15:8] == 8'hBC) && (c_instr[1:0] == 2'b10);
  assign is_popret  = (c_instr[15:8] == 8'hBE) && (c_instr[1:0] == 2'b10);
  assign is_pp      = is_push | is_pop | is_popret | is_popretz;
  assign is_mv      = (c_instr[15:10] == 6'b101011) && (c_instr[1:0] == 2'b10);
  assign is_mvsa    = is_mv && (c_instr[6:5] == 2'b01);
  assign is_mva     = is_mv && (c_instr[6:5] == 2'b11);

  assign rlist_ok   = ({1'b0, rlist} >= RLIST_MIN_L);

  // Reserved rlist values and mvsa01 with identical targets stay whole so the
  // decoder can flag them.
  assign expand = ZC_EN && instr_compressed_i &&
                  ((is_pp && rlist_ok) || is_mva || (is_mvsa && (r1s != r2s)));

  // ---------------------------------------------------------------------------
  // Stack adjustment and sequence length
  // ---------------------------------------------------------------------------
  assign n_regs     = (rlist == 4'd15) ? 4'd13 : (rlist - 4'd3);
  assign bytes_regs = {2'b00, n_regs, 2'b00};
  assign adj        = ((bytes_regs + 8'd15) & 8'hF0) + {2'b00, spimm, 4'b0000};
  assign adj12      = {4'd0, adj};

  always_comb begin
    len_m1 = 4'd1;
    if (is_push || is_pop) len_m1 = n_regs;
    else if (is_popret)    len_m1 = n_regs + 4'd1;
    else if (is_popretz)   len_m1 = n_regs + 4'd2;
  end

  assign is_last = (cnt_q == len_m1);

  // ---------------------------------------------------------------------------
  // Micro-op generation from the held instruction and the uop index
  // ---------------------------------------------------------------------------
  assign tail_k  = cnt_q - n_regs;
  assign reg_idx = n_regs - 4'd1 - cnt_q;
  assign off4    = {6'd0, cnt_q, 2'b00} + 12'd4;

  // Build uop cnt_q of the current expandable instruction
  always_comb begin
    gen_uop = 32'd0;
    if (is_push) begin
      if (cnt_q < n_regs) gen_uop = enc_store(rlist_reg(reg_idx), REG_SP, 12'd0 - off4);
      else                gen_uop = enc_itype(REG_SP, REG_SP, 3'b000, OPC_OPIMM, 12'd0 - adj12);
    end else if (is_pp) begin
      if (cnt_q < n_regs) begin
        gen_uop = enc_itype(rlist_reg(reg_idx), REG_SP, 3'b010, OPC_LOAD, adj12 - off4);
      end else if (is_popretz && (tail_k == 4'd0)) begin
        gen_uop = enc_itype(REG_A0, REG_ZERO, 3'b000, OPC_OPIMM, 12'd0);
      end else if (tail_k == (is_popretz ? 4'd1 : 4'd0)) begin
        gen_uop = enc_itype(REG_SP, REG_SP, 3'b000, OPC_OPIMM, adj12);
      end else begin
        gen_uop = enc_itype(REG_ZERO, REG_RA, 3'b000, OPC_JALR, 12'd0);
      end
    end else if (is_mvsa) begin
      if (cnt_q == 4'd0) gen_uop = enc_itype(sreg(r1s), REG_A0, 3'b000, OPC_OPIMM, 12'd0);
      else               gen_uop = enc_itype(sreg(r2s), REG_A1, 3'b000, OPC_OPIMM, 12'd0);
    end else if (is_mva) begin
      if (cnt_q == 4'd0) gen_uop = enc_itype(REG_A0, sreg(r1s), 3'b000, OPC_OPIMM, 12'd0);
      else               gen_uop = enc_itype(REG_A1, sreg(r2s), 3'b000, OPC_OPIMM, 12'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State and uop counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: kill wins, otherwise advance on every accepted uop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (kill_i) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid_i && expand && uop_ready_i) begin
            state_d = S_SEQ;
            cnt_d   = 4'd1;
          end
        end
        S_SEQ: begin
          if (uop_ready_i) begin
            if (is_last) begin
              state_d = S_IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Outputs: pass-through by default, generated uops when expanding
  always_comb begin
    uop_o         = instr_i;
    uop_valid_o   = instr_valid_i;
    uop_first_o   = 1'b1;
    uop_last_o    = 1'b1;
    instr_ready_o = uop_ready_i;
    if (state_q == S_SEQ) begin
      uop_o         = gen_uop;
      uop_valid_o   = 1'b1;
      uop_first_o   = (cnt_q == 4'd0);
      uop_last_o    = is_last;
      instr_ready_o = uop_ready_i & is_last;
    end else if (expand) begin
      uop_o         = gen_uop;
      uop_first_o   = (cnt_q == 4'd0);
      uop_last_o    = is_last;
      instr_ready_o = 1'b0;
    end
    if (kill_i) begin
      uop_valid_o   = 1'b0;
      instr_ready_o = 1'b0;
    end
    // Outputs read as their reset values for as long as reset is held
    if (!rst_n) begin
      uop_o         = 32'd0;
      uop_valid_o   = 1'b0;
      uop_first_o   = 1'b0;
      uop_last_o    = 1'b0;
      instr_ready_o = 1'b0;
    end
  end

  assign seq_active_o = (state_q == S_SEQ);

`ifndef SYNTHESIS
  // Upstream must hold the instruction while a sequence is in progress
  a_instr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    seq_active_o |-> ($stable(instr_i) && $stable(instr_compressed_i)))
    else $error("instr_i changed while a uop sequence was active");
`endif

endmodule
`default_nettype wire
